// File: rtl/led_sequence_driver.sv
// ---------------------------------------------------------------------------
// led_sequence_driver
//
// Output side of the Genius game. A 2-bit colour code from the controller is
// turned into a timed one-hot pulse on the four colour LEDs, followed by an
// all-dark gap. A separate request produces an all-LED blink pattern, used
// for win/fail indication. The controller steps through a stored sequence
// with a request/done handshake, one item at a time.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable_led   single-item display request (sampled only when idle)
//   color        colour code: 00 green, 01 red, 10 blue, 11 yellow
//   speed        1 = fast on-time, 0 = slow on-time (sampled with enable_led)
//   all_leds     all-LED blink request (sampled only when idle, wins a tie)
//   busy         high while a display or blink is in progress
//   done         one-cycle pulse when an item or blink sequence completes
//   led_green/led_red/led_blue/led_yellow   registered LED drives, active high
// ---------------------------------------------------------------------------
module led_sequence_driver #(
    parameter int COLOR_CODEFY_W = 2,
    parameter int CNT_W          = 26,
    parameter int FAST_ON_CYCLES = 12_500_000,
    parameter int SLOW_ON_CYCLES = 25_000_000,
    parameter int GAP_CYCLES     = 5_000_000,
    parameter int FLASH_CYCLES   = 10_000_000,
    parameter int FLASH_COUNT    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_led,
    input  logic [COLOR_CODEFY_W-1:0] color,
    input  logic                      speed,
    input  logic                      all_leds,
    output logic                      busy,
    output logic                      done,
    output logic                      led_green,
    output logic                      led_red,
    output logic                      led_blue,
    output logic                      led_yellow
);

    // Flash counter needs at least one bit even when FLASH_COUNT is 1.
    localparam int FC_W = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

    localparam logic [CNT_W-1:0] FAST_LD  = CNT_W'(FAST_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOW_LD  = CNT_W'(SLOW_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FLASH_COUNT - 1);

    // Parameter sanity: durations must be at least one cycle and every
    // reload value must fit the counter.
    localparam longint CNT_LIM = longint'(1) << CNT_W;
    if (COLOR_CODEFY_W != 2) begin : g_bad_color_w
        $error("COLOR_CODEFY_W must be 2");
    end
    if (FAST_ON_CYCLES < 1 || SLOW_ON_CYCLES < 1 || GAP_CYCLES < 1 ||
        FLASH_CYCLES < 1 || FLASH_COUNT < 1) begin : g_bad_min
        $error("duration and count parameters must be >= 1");
    end
    if (longint'(FAST_ON_CYCLES) - 1 >= CNT_LIM ||
        longint'(SLOW_ON_CYCLES) - 1 >= CNT_LIM ||
        longint'(GAP_CYCLES)     - 1 >= CNT_LIM ||
        longint'(FLASH_CYCLES)   - 1 >= CNT_LIM) begin : g_bad_fit
        $error("duration parameters do not fit in CNT_W bits");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHOW      = 3'd1,
        GAP       = 3'd2,
        FLASH_ON  = 3'd3,
        FLASH_OFF = 3'd4
    } state_t;

    state_t                      state, state_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic [FC_W-1:0]             fcnt, fcnt_nxt;
    logic [COLOR_CODEFY_W-1:0]   color_q, color_nxt;
    logic                        speed_q, speed_nxt;
    logic                        done_nxt;
    logic [3:0]                  led_nxt;   // {green, red, blue, yellow}

    always_comb begin
        state_nxt = state;
        // Saturating down-count; every non-idle state ends when this reads 0.
        cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : '0;
        fcnt_nxt  = fcnt;
        color_nxt = color_q;
        speed_nxt = speed_q;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = cnt;
                if (all_leds) begin
                    state_nxt = FLASH_ON;
                    cnt_nxt   = FLASH_LD;
                    fcnt_nxt  = '0;
                end else if (enable_led) begin
                    state_nxt = SHOW;
                    color_nxt = color;
                    speed_nxt = speed;
                    cnt_nxt   = speed ? FAST_LD : SLOW_LD;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            FLASH_ON: begin
                if (cnt == '0) begin
                    state_nxt = FLASH_OFF;
                    cnt_nxt   = FLASH_LD;
                end
            end
            FLASH_OFF: begin
                if (cnt == '0) begin
                    if (fcnt == FC_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = FLASH_ON;
                        fcnt_nxt  = fcnt + FC_W'(1);
                        cnt_nxt   = FLASH_LD;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // LEDs are a decode of the next state so they change on the same
        // edge that accepts a request.
        led_nxt = 4'b0000;
        if (state_nxt == SHOW)
            led_nxt = 4'b1000 >> color_nxt;
        else if (state_nxt == FLASH_ON)
            led_nxt = 4'b1111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            fcnt       <= '0;
            color_q    <= '0;
            speed_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            led_green  <= 1'b0;
            led_red    <= 1'b0;
            led_blue   <= 1'b0;
            led_yellow <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            fcnt       <= fcnt_nxt;
            color_q    <= color_nxt;
            speed_q    <= speed_nxt;
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
            led_green  <= led_nxt[3];
            led_red    <= led_nxt[2];
            led_blue   <= led_nxt[1];
            led_yellow <= led_nxt[0];
        end
    end

endmodule
